div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage.
- Serves DIV/DIVU: quotient goes to LO, remainder goes to HI.
- Acts as the writer side of the HI/LO register: its one-cycle ready pulse drives the HI/LO write enable, and hi_o/lo_o drive the HI/LO data inputs.
- Stalls the pipeline while a division is in flight.

Parameters:
- WIDTH, 32, operand/result width; must be at least 2; iteration counter is clog2(WIDTH) bits.

Ports:
- cpu_clk_50M  input  1  clock; all state updates on the rising edge
- cpu_rst_n  input  1  asynchronous active-low reset
- start_i  input  1  request a division; sampled only in FREE
- signed_i  input  1  1=DIV (two's complement), 0=DIVU; sampled with start_i
- annul_i  input  1  flush/exception cancel of the in-flight operation
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- stall_o  output  1  pipeline stall request (combinational)
- ready_o  output  1  one-cycle pulse: hi_o/lo_o are new; doubles as HI/LO write enable
- hi_o  output  WIDTH  remainder, registered
- lo_o  output  WIDTH  quotient, registered

Behaviour:
- Reset (asynchronous, cpu_rst_n=0): state=FREE, ready_o=0, hi_o=0, lo_o=0, counter=0, takes effect immediately; applying it mid-operation aborts with no ready_o.
- State machine: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0 -> latch operand magnitudes, signed_i and result signs.
  - Divisor 0 -> BYZERO; otherwise ON with counter=0.
  - annul_i=1 blocks acceptance (annul wins over start).
- BYZERO: next edge -> END with quotient=0, remainder=0.
- ON:
  - One restoring step per edge: shift the partial remainder left by 1 bringing in the next dividend MSB; subtract the divisor if no borrow; the quotient bit is the inverse of borrow.
  - After WIDTH edges (counter reaching WIDTH-1) -> END, with final signed fix-up written into hi_o/lo_o on that edge.
- END: ready_o=1 for this single cycle; next edge -> FREE unconditionally.
- annul_i=1 in BYZERO/ON -> next edge FREE; no ready_o; hi_o/lo_o keep their previous values. annul_i in END is ignored (result already committed).
- start_i outside FREE is ignored; no queuing.
- Latency: acceptance cycle = cycle 0; ready_o is high in cycle WIDTH+1 (33 for WIDTH=32); divide-by-zero ready_o is in cycle 2.
- stall_o = (FREE & start_i & ~annul_i) | ON | BYZERO; 0 in END so EX advances with the result.
- Signed rules:
  - Divide magnitudes unsigned.
  - Quotient negated iff the operand signs differ (truncation toward zero).
  - Remainder takes the dividend's sign.
  - Most-negative / -1: quotient = 0x80000000, remainder = 0 (falls out of the magnitude path, no special case).
- hi_o/lo_o change only on the edge entering END; they hold until the next completed division.
- Operands may change after acceptance without affecting the result.

Optional Feature:
- Macro DIV_BYZERO_FLAG_EN.
- Defined: extra output port div_zero_o (1 bit), high with ready_o only for operations that passed through BYZERO; reset value 0.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Unsigned 100/7, start at cycle 0 -> stall_o high cycles 0-32, ready_o only in cycle 33, lo_o=14, hi_o=2.
- Signed 0xFFFFFFF9/2 (-7/2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; signed 7/0xFFFFFFFE -> lo_o=0xFFFFFFFD, hi_o=1.
- Signed 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0; unsigned 0xFFFFFFFF/0x10 -> lo_o=0x0FFFFFFF, hi_o=0xF.
- Divisor 0 (signed and unsigned) -> ready_o in cycle 2, hi_o=lo_o=0, stall_o low in cycle 2; div_zero_o=1 with macro.
- Complete 100/7, then start 50/3 and pulse annul_i in cycle 10 -> no ready_o, state FREE in cycle 11, hi_o=2 and lo_o=14 retained; start_i held high during ON has no effect.
- Drop cpu_rst_n in cycle 15 of an operation -> hi_o/lo_o/ready_o=0 immediately; after release, a new 9/3 gives lo_o=3, hi_o=0 at cycle 33.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) driving the HI/LO write port.
// Optional macro DIV_BYZERO_FLAG_EN adds div_zero_o.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  output logic             stall_o,
  output logic             ready_o,
`ifdef DIV_BYZERO_FLAG_EN
  output logic             div_zero_o,
`endif
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    FREE,
    BYZERO,
    ON,
    END
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0] trial, diff;
  logic borrow;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  assign a_mag = (signed_i & opdata1_i[WIDTH-1])
               ? {WIDTH{1'b0}} - opdata1_i : opdata1_i;
  assign b_mag = (signed_i & opdata2_i[WIDTH-1])
               ? {WIDTH{1'b0}} - opdata2_i : opdata2_i;

  // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom
  assign trial   = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = trial - {1'b0, dvs_q};
  assign borrow  = diff[WIDTH];
  assign rem_nx  = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx  = {dvd_q[WIDTH-2:0], ~borrow};
  assign quo_fix = negq_q ? {WIDTH{1'b0}} - quo_nx : quo_nx;
  assign rem_fix = negr_q ? {WIDTH{1'b0}} - rem_nx : rem_nx;

`ifdef DIV_BYZERO_FLAG_EN
  logic zf_q, zf_d;
  assign div_zero_o = ready_o & zf_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
`ifdef DIV_BYZERO_FLAG_EN
    zf_d    = zf_q;
`endif
    stall_o = 1'b0;
    ready_o = 1'b0;
    unique case (state_q)
      FREE: begin
        if (start_i & ~annul_i) begin
          stall_o = 1'b1;
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          cnt_d   = '0;
          negq_d  = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          negr_d  = signed_i & opdata1_i[WIDTH-1];
`ifdef DIV_BYZERO_FLAG_EN
          zf_d    = (opdata2_i == '0);
`endif
          state_d = (opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_d = FREE;
        end else begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = END;
        end
      end
      ON: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_d = FREE;
        end else begin
          rem_d = rem_nx;
          dvd_d = quo_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            hi_d    = rem_fix;
            lo_d    = quo_fix;
            state_d = END;
          end
        end
      end
      END: begin
        ready_o = 1'b1;
        state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= FREE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
      zf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`ifdef DIV_BYZERO_FLAG_EN
      zf_q    <= zf_d;
`endif
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
